// File: rtl/treino_pkg.sv
// Shared types and FP16 constants for the perceptron training sequencer.
package treino_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CALC,
    ST_ATIV,
    ST_CHECK,
    ST_UPD0,
    ST_UPD1,
    ST_UPD2,
    ST_NEXT,
    ST_EPOCH
  } treino_state_e;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam int          SIGN_BIT  = 15;
  localparam int          EPOCH_W   = 8;

  // Negate an FP16 value by flipping its sign bit, so the adder can form d + (-y).
  function automatic logic [15:0] fp16_neg(input logic [15:0] h);
    return {~h[SIGN_BIT], h[SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/treino_amostras.sv
// Sample RAM: N_MAX words of {d, x2, x1, x0}, synchronous write, asynchronous read.
module treino_amostras #(
  parameter int TAM   = 16,
  parameter int N_MAX = 8
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(N_MAX)-1:0]   wr_addr_i,
  input  logic [4*TAM-1:0]           wr_data_i,
  input  logic [$clog2(N_MAX)-1:0]   rd_addr_i,
  output logic [4*TAM-1:0]           rd_data_o
);

  logic [4*TAM-1:0] mem_q [N_MAX];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/treino_ctrl.sv
// Perceptron training sequencer: walks calc_v -> activation -> weight update per sample, per epoch.
// Optional status outputs epoch_cnt/err_cnt are built when TREINO_STATUS_EN is defined.
module treino_ctrl
  import treino_pkg::*;
#(
  parameter int TAM       = 16,
  parameter int N_MAX     = 8,
  parameter int LAT       = 2,
  parameter int MAX_EPOCH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(N_MAX):0]     n_samples,
  input  logic [TAM-1:0]             u,
  input  logic                       s_we,
  input  logic [$clog2(N_MAX)-1:0]   s_addr,
  input  logic [4*TAM-1:0]           s_data,
  input  logic                       w_ld,
  input  logic [3*TAM-1:0]           w_ld_data,
  output logic                       busy,
  output logic                       done,
  output logic                       converged,
  output logic [3*TAM-1:0]           w_out,
  output logic                       dp_calc_en,
  output logic [3*TAM-1:0]           dp_x,
  output logic [3*TAM-1:0]           dp_w,
  input  logic [TAM-1:0]             dp_v,
  output logic                       dp_ativ_en,
  input  logic [TAM-1:0]             dp_y,
  output logic                       dp_att_en,
  output logic [TAM-1:0]             dp_att_d,
  output logic [TAM-1:0]             dp_att_y,
  output logic [TAM-1:0]             dp_att_in,
  output logic [TAM-1:0]             dp_att_u,
  output logic [TAM-1:0]             dp_att_w_in,
  input  logic [TAM-1:0]             dp_att_w_out
`ifdef TREINO_STATUS_EN
  ,
  output logic [7:0]                 epoch_cnt,
  output logic [$clog2(N_MAX):0]     err_cnt
`endif
);

  localparam int IW = $clog2(N_MAX);
  localparam int NW = IW + 1;
  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

  treino_state_e      state_q, state_d;
  logic [LW-1:0]      lat_q;
  logic               lat_last;
  logic               stage_timed;
  logic [IW-1:0]      idx_q;
  logic [NW-1:0]      n_q;
  logic [NW-1:0]      err_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic               done_q;
  logic               conv_q;
  logic [TAM-1:0]     u_q;
  logic [TAM-1:0]     v_q;
  logic [TAM-1:0]     y_q;
  logic [3*TAM-1:0]   w_q;
  logic [4*TAM-1:0]   smp;
  logic [TAM-1:0]     smp_d;
  logic               more_samples;
  logic               last_epoch;
  logic               mismatch;

  treino_amostras #(
    .TAM   (TAM),
    .N_MAX (N_MAX)
  ) u_amostras (
    .clk_i     (clk),
    .we_i      (s_we && (state_q == ST_IDLE)),
    .wr_addr_i (s_addr),
    .wr_data_i (s_data),
    .rd_addr_i (idx_q),
    .rd_data_o (smp)
  );

  assign smp_d        = smp[4*TAM-1:3*TAM];
  assign lat_last     = (lat_q == LW'(LAT - 1));
  assign more_samples = ((NW'(idx_q) + NW'(1)) < n_q);
  assign last_epoch   = (epoch_q == EPOCH_W'(MAX_EPOCH - 1));
  assign mismatch     = (y_q != smp_d);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && (n_samples != '0)) state_d = ST_CALC;
      ST_CALC:  if (lat_last) state_d = ST_ATIV;
      ST_ATIV:  if (lat_last) state_d = ST_CHECK;
      ST_CHECK: state_d = mismatch ? ST_UPD0 : ST_NEXT;
      ST_UPD0:  if (lat_last) state_d = ST_UPD1;
      ST_UPD1:  if (lat_last) state_d = ST_UPD2;
      ST_UPD2:  if (lat_last) state_d = ST_NEXT;
      ST_NEXT:  state_d = more_samples ? ST_CALC : ST_EPOCH;
      ST_EPOCH: state_d = ((err_q == '0) || last_epoch) ? ST_IDLE : ST_CALC;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: one enable per state, operand mux follows the update slot
  always_comb begin
    dp_calc_en  = 1'b0;
    dp_ativ_en  = 1'b0;
    dp_att_en   = 1'b0;
    stage_timed = 1'b0;
    dp_att_in   = smp[TAM-1:0];
    dp_att_w_in = w_q[TAM-1:0];
    case (state_q)
      ST_CALC: begin
        dp_calc_en  = 1'b1;
        stage_timed = 1'b1;
      end
      ST_ATIV: begin
        dp_ativ_en  = 1'b1;
        stage_timed = 1'b1;
      end
      ST_UPD0: begin
        dp_att_en   = 1'b1;
        stage_timed = 1'b1;
      end
      ST_UPD1: begin
        dp_att_en   = 1'b1;
        stage_timed = 1'b1;
        dp_att_in   = smp[2*TAM-1:TAM];
        dp_att_w_in = w_q[2*TAM-1:TAM];
      end
      ST_UPD2: begin
        dp_att_en   = 1'b1;
        stage_timed = 1'b1;
        dp_att_in   = smp[3*TAM-1:2*TAM];
        dp_att_w_in = w_q[3*TAM-1:2*TAM];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q <= '0;
    end else if (stage_timed && !lat_last) begin
      lat_q <= lat_q + LW'(1);
    end else begin
      lat_q <= '0;
    end
  end

  // Sample index, error/epoch counters and completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      n_q     <= '0;
      err_q   <= '0;
      epoch_q <= '0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_q     <= n_samples;
            idx_q   <= '0;
            err_q   <= '0;
            epoch_q <= '0;
            conv_q  <= 1'b0;
            if (n_samples == '0) begin
              done_q <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_q <= err_q + NW'(1);
          end
        end
        ST_NEXT: begin
          if (more_samples) begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_EPOCH: begin
          if (err_q == '0) begin
            conv_q <= 1'b1;
            done_q <= 1'b1;
          end else if (last_epoch) begin
            conv_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            err_q   <= '0;
            idx_q   <= '0;
            epoch_q <= epoch_q + EPOCH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath captures; v is held only for debug probing
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && start) begin
      u_q <= u;
    end
    if ((state_q == ST_CALC) && lat_last) begin
      v_q <= dp_v;
    end
    if ((state_q == ST_ATIV) && lat_last) begin
      y_q <= dp_y;
    end
  end

  logic unused_v;
  assign unused_v = ^v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= {3{FP16_ZERO}};
    end else if ((state_q == ST_IDLE) && w_ld) begin
      w_q <= w_ld_data;
    end else if (lat_last) begin
      case (state_q)
        ST_UPD0: w_q[TAM-1:0]       <= dp_att_w_out;
        ST_UPD1: w_q[2*TAM-1:TAM]   <= dp_att_w_out;
        ST_UPD2: w_q[3*TAM-1:2*TAM] <= dp_att_w_out;
        default: ;
      endcase
    end
  end

`ifdef TREINO_STATUS_EN
  logic [7:0]    epoch_cnt_q;
  logic [NW-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      epoch_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (state_q == ST_EPOCH) begin
      epoch_cnt_q <= epoch_cnt_q + 8'd1;
      err_cnt_q   <= err_q;
    end
  end

  assign epoch_cnt = epoch_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign converged = conv_q;
  assign w_out     = w_q;
  assign dp_x      = smp[3*TAM-1:0];
  assign dp_w      = w_q;
  assign dp_att_d  = smp_d;
  assign dp_att_y  = fp16_neg(y_q);
  assign dp_att_u  = u_q;

endmodule

// File: tb/tb_treino_ctrl.sv
// Bench for treino_ctrl: FP16 datapath model, table of training cases, perceptron reference scoreboard.
module tb_treino_ctrl;

  localparam int TAM   = 16;
  localparam int N_MAX = 8;
  localparam int LAT   = 2;
  localparam int ME    = 8;
  localparam int IW    = 3;
  localparam int NW    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [NW-1:0]   n_samples = '0;
  logic [15:0]     u = '0;
  logic            s_we = 1'b0;
  logic [IW-1:0]   s_addr = '0;
  logic [63:0]     s_data = '0;
  logic            w_ld = 1'b0;
  logic [47:0]     w_ld_data = '0;
  logic            busy, done, converged;
  logic [47:0]     w_out, dp_x, dp_w;
  logic            dp_calc_en, dp_ativ_en, dp_att_en;
  logic [15:0]     dp_v, dp_y, dp_att_w_out;
  logic [15:0]     dp_att_d, dp_att_y, dp_att_in, dp_att_u, dp_att_w_in;
`ifdef TREINO_STATUS_EN
  logic [7:0]      epoch_cnt;
  logic [NW-1:0]   err_cnt;
`endif

  treino_ctrl #(.TAM(TAM), .N_MAX(N_MAX), .LAT(LAT), .MAX_EPOCH(ME)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .u(u),
    .s_we(s_we), .s_addr(s_addr), .s_data(s_data), .w_ld(w_ld), .w_ld_data(w_ld_data),
    .busy(busy), .done(done), .converged(converged), .w_out(w_out),
    .dp_calc_en(dp_calc_en), .dp_x(dp_x), .dp_w(dp_w), .dp_v(dp_v),
    .dp_ativ_en(dp_ativ_en), .dp_y(dp_y), .dp_att_en(dp_att_en),
    .dp_att_d(dp_att_d), .dp_att_y(dp_att_y), .dp_att_in(dp_att_in),
    .dp_att_u(dp_att_u), .dp_att_w_in(dp_att_w_in), .dp_att_w_out(dp_att_w_out)
`ifdef TREINO_STATUS_EN
    , .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    int  e;
    real r;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    r = 1.0 + real'(int'(h[9:0])) / 1024.0;
    while (e > 15) begin r = r * 2.0; e--; end
    while (e < 15) begin r = r / 2.0; e++; end
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  a;
    int   e;
    int   m;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    while (a >= 2.0 && e < 30) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
    m = int'((a - 1.0) * 1024.0);
    return {s, 5'(e), 10'(m)};
  endfunction

  // Datapath model: dot product, step activation (v >= 0 -> 1.0), w + u*(d + (-y))*x
  always_comb begin
    dp_v = r2h(h2r(dp_w[15:0]) * h2r(dp_x[15:0]) + h2r(dp_w[31:16]) * h2r(dp_x[31:16])
               + h2r(dp_w[47:32]) * h2r(dp_x[47:32]));
    dp_y = (dp_v[15] == 1'b0 || dp_v == 16'h8000) ? 16'h3C00 : 16'h0000;
    dp_att_w_out = r2h(h2r(dp_att_w_in)
                       + h2r(dp_att_u) * (h2r(dp_att_d) + h2r(dp_att_y)) * h2r(dp_att_in));
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Enable exclusivity and operand stability within each LAT-cycle window
  logic [2:0]   en_w, prev_en;
  logic [175:0] ops_w, prev_ops;
  int           run_q = 0;
  int           viol_onehot = 0;
  int           viol_stab = 0;
  logic [15:0]  last_atty = '0;
  assign en_w  = {dp_calc_en, dp_ativ_en, dp_att_en};
  assign ops_w = {dp_x, dp_w, dp_att_d, dp_att_y, dp_att_in, dp_att_u, dp_att_w_in};

  always @(negedge clk) begin
    if ($countones(en_w) > 1) viol_onehot <= viol_onehot + 1;
    if (en_w != 3'b000 && en_w == prev_en) begin
      run_q <= run_q + 1;
      if (((run_q + 1) % LAT) != 0 && ops_w != prev_ops) viol_stab <= viol_stab + 1;
    end else begin
      run_q <= 0;
    end
    if (dp_att_en) last_atty <= dp_att_y;
    prev_en  <= en_w;
    prev_ops <= ops_w;
  end

  typedef struct {
    logic [47:0] w0;
    int          n;
    logic [63:0] s [4];
    logic [15:0] u;
    logic        has_w;
    logic [47:0] exp_w;
    logic        chk_atty;
    logic        poke;
  } case_t;

  typedef struct {
    logic [47:0] w;
    logic        conv;
    int          busy;
    int          att;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t ref_model(input case_t c);
    real  w[3];
    real  x[3];
    real  d, v, y, uu;
    int   errs;
    exp_t e;
    for (int k = 0; k < 3; k++) w[k] = h2r(c.w0[16*k +: 16]);
    uu = h2r(c.u);
    e.busy = 0; e.att = 0; e.conv = 1'b0;
    for (int ep = 0; ep < ME; ep++) begin
      errs = 0;
      for (int i = 0; i < c.n; i++) begin
        for (int k = 0; k < 3; k++) x[k] = h2r(c.s[i][16*k +: 16]);
        d = h2r(c.s[i][63:48]);
        v = w[0] * x[0] + w[1] * x[1] + w[2] * x[2];
        y = (v >= 0.0) ? 1.0 : 0.0;
        if (y != d) begin
          errs++;
          for (int k = 0; k < 3; k++) w[k] = w[k] + uu * (d - y) * x[k];
          e.busy += 5 * LAT + 2;
          e.att  += 3 * LAT;
        end else begin
          e.busy += 2 * LAT + 2;
        end
      end
      e.busy += 1;
      if (errs == 0) begin
        e.conv = 1'b1;
        break;
      end
    end
    for (int k = 0; k < 3; k++) e.w[16*k +: 16] = r2h(w[k]);
    return e;
  endfunction

  task automatic load_case(input case_t c);
    @(negedge clk);
    for (int i = 0; i < c.n; i++) begin
      s_we = 1'b1; s_addr = IW'(i); s_data = c.s[i];
      w_ld = (i == 0); w_ld_data = c.w0;
      @(negedge clk);
    end
    s_we = 1'b0; w_ld = 1'b0;
  endtask

  task automatic run_case(input string nm, input case_t c);
    exp_t e;
    int   bc, ac, cyc;
    load_case(c);
    sb.push_back(ref_model(c));
    n_samples = NW'(c.n); u = c.u; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0; ac = 0; cyc = 0;
    while (!done && cyc < 5000) begin
      if (busy) bc++;
      if (dp_att_en) ac++;
      if (c.poke && cyc == 3) begin
        start = 1'b1; w_ld = 1'b1; w_ld_data = '1; s_we = 1'b1; s_addr = '0; s_data = '1;
      end else begin
        start = 1'b0; w_ld = 1'b0; s_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; w_ld = 1'b0; s_we = 1'b0;
    chk({nm, "_done_seen"}, done, 1'b1);
    e = sb.pop_front();
    chk({nm, "_w"}, w_out, e.w);
    chk({nm, "_converged"}, converged, e.conv);
    chk({nm, "_busy_cycles"}, bc, e.busy);
    chk({nm, "_att_cycles"}, ac, e.att);
    chk({nm, "_busy_at_done"}, busy, 1'b0);
    if (c.has_w) chk({nm, "_w_hand"}, w_out, c.exp_w);
    if (c.chk_atty) chk({nm, "_att_y"}, last_atty, 16'hBC00);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 1'b0);
  endtask

  case_t tc[4];
  logic [47:0] w_saved;
  int          att_seen;
  int          cyc;
  logic        saw_done;

  initial begin
    tc[0] = '{w0: 48'h0, n: 1, s: '{64'h0000_3C00_3C00_3C00, 64'h0, 64'h0, 64'h0},
              u: 16'h3800, has_w: 1'b1, exp_w: 48'hB800_B800_B800, chk_atty: 1'b1, poke: 1'b0};
    tc[1] = '{w0: 48'h3C00_3C00_BC00, n: 1, s: '{64'h3C00_3C00_0000_3C00, 64'h0, 64'h0, 64'h0},
              u: 16'h3800, has_w: 1'b1, exp_w: 48'h3C00_3C00_BC00, chk_atty: 1'b0, poke: 1'b0};
    tc[2] = '{w0: 48'h0, n: 4,
              s: '{64'h0000_3C00_0000_0000, 64'h3C00_3C00_3C00_0000,
                   64'h3C00_3C00_0000_3C00, 64'h0000_3C00_3C00_3C00},
              u: 16'h3800, has_w: 1'b0, exp_w: 48'h0, chk_atty: 1'b0, poke: 1'b0};
    tc[3] = '{w0: 48'h0, n: 4,
              s: '{64'h3C00_3C00_3C00_3C00, 64'h0000_3C00_0000_0000,
                   64'h0000_3C00_3C00_0000, 64'h0000_3C00_0000_3C00},
              u: 16'h3800, has_w: 1'b0, exp_w: 48'h0, chk_atty: 1'b0, poke: 1'b1};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_converged", converged, 1'b0);
    chk("rst_w", w_out, 48'h0);
    chk("rst_en", {dp_calc_en, dp_ativ_en, dp_att_en}, 3'b000);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_case($sformatf("case%0d", i), tc[i]);
    chk("and_converged_flag", converged, 1'b1);

    // Zero samples: immediate done, converged cleared, weights untouched
    w_saved = w_out;
    @(negedge clk);
    n_samples = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("n0_done", done, 1'b1);
    chk("n0_busy", busy, 1'b0);
    chk("n0_converged", converged, 1'b0);
    chk("n0_w", w_out, w_saved);
    @(negedge clk);
    chk("n0_done_pulse", done, 1'b0);

    // Reset during UPD1: run aborts with no done pulse
    load_case(tc[0]);
    n_samples = 4'd1; u = 16'h3800; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    att_seen = 0; cyc = 0;
    while (att_seen < LAT + 1 && cyc < 200) begin
      if (dp_att_en) att_seen++;
      if (att_seen < LAT + 1) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("midrst_reached_upd1", att_seen, LAT + 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_att_en", dp_att_en, 1'b0);
    chk("midrst_w", w_out, 48'h0);
    saw_done = done;
    repeat (5) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk("midrst_no_done", saw_done, 1'b0);
    run_case("after_rst", tc[0]);

    chk("onehot_enables", viol_onehot, 0);
    chk("stable_operands", viol_stab, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/treino_ctrl.md
Name: treino_ctrl

Overview:
- Training sequencer for the single-neuron perceptron: holds the weight registers and a small sample memory.
- Drives the shared FP16 datapath through calc_v, then activation, then weight update, one sample at a time, over whole epochs.
- Time-multiplexes the single weight-update unit across the three weights.
- Stops when an epoch has zero misclassifications or MAX_EPOCH is reached.

Parameters:
- TAM, 16, word width (IEEE half precision).
- N_MAX, 8, sample memory depth (power of 2).
- LAT, 2, datapath settle cycles per stage, minimum 1.
- MAX_EPOCH, 64, epoch limit.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins training when idle.
- n_samples  in  $clog2(N_MAX)+1  sample count, 1..N_MAX; sampled on start.
- u  in  TAM  learning rate; sampled on start.
- s_we  in  1  sample memory write; ignored while busy.
- s_addr  in  $clog2(N_MAX)  write address.
- s_data  in  4*TAM  {d, x2, x1, x0}.
- w_ld  in  1  load weights; ignored while busy.
- w_ld_data  in  3*TAM  {w2, w1, w0}.
- busy  out  1  training in progress.
- done  out  1  one-cycle pulse at end of training.
- converged  out  1  last run ended with a zero-error epoch.
- w_out  out  3*TAM  current weights {w2, w1, w0}.
- dp_calc_en  out  1  enable for calc_v.
- dp_x  out  3*TAM  current sample inputs.
- dp_w  out  3*TAM  current weights.
- dp_v  in  TAM  calc_v result.
- dp_ativ_en  out  1  enable for activation.
- dp_y  in  TAM  activation result (16'h3C00 or 16'h0000).
- dp_att_en  out  1  enable for weight update.
- dp_att_d  out  TAM  desired output.
- dp_att_y  out  TAM  registered y with sign bit inverted, so that d + (−y) yields the error.
- dp_att_in  out  TAM  selected input xk.
- dp_att_u  out  TAM  learning rate.
- dp_att_w_in  out  TAM  selected weight wk.
- dp_att_w_out  in  TAM  updated weight.

Behaviour:
- Reset values:
  - busy = done = converged = 0.
  - Weights = 0.
  - All dp_*_en = 0.
  - FSM = IDLE; counters = 0.
  - Sample memory is not cleared.
- FSM states and transitions:
  - IDLE → CALC on start.
  - CALC: dp_calc_en = 1 for LAT cycles; on the last cycle, register v = dp_v → ATIV.
  - ATIV: dp_ativ_en = 1 for LAT cycles; on the last cycle, register y = dp_y → CHECK.
  - CHECK (1 cycle):
    - If y == d bitwise → NEXT.
    - Else increment the epoch error counter → UPD0.
  - UPDk (k = 0, 1, 2): dp_att_en = 1 with operands xk / wk for LAT cycles; on the last cycle, wk ← dp_att_w_out → UPD(k+1), or NEXT after UPD2.
  - NEXT (1 cycle):
    - If sample index < n_samples−1 → increment index → CALC.
    - Else → EPOCH.
  - EPOCH (1 cycle):
    - If error counter == 0 → converged = 1, done → IDLE.
    - Else if epoch counter == MAX_EPOCH−1 → converged = 0, done → IDLE.
    - Else clear error counter, index ← 0, increment epoch counter → CALC.
- Per-sample latency: 2*LAT+2 cycles when correct; 5*LAT+2 cycles when an update is made.
- Only one dp_*_en is high in any cycle. Datapath operands are held stable for the whole enable window.
- busy is high from the cycle after start through the EPOCH cycle. done is asserted in the cycle the FSM returns to IDLE.
- start while busy: ignored. start with n_samples == 0: done pulse next cycle, converged = 0, weights unchanged.
- s_we and w_ld both in IDLE in the same cycle: both take effect.
- rst mid-run: abort immediately to reset values; no done pulse.

Optional Feature:
- Macro: TREINO_STATUS_EN.
- When defined, add two outputs:
  - epoch_cnt (8 bits): epochs completed in the current/last run.
  - err_cnt ($clog2(N_MAX)+1 bits): errors in the last completed epoch.
  - Both clear on start and on rst.
- When not defined, the outputs are absent; the internal counters still exist for FSM use.

Decomposition:
- Package treino_pkg:
  - FSM state enum.
  - Constants FP16_ONE = 16'h3C00, FP16_ZERO = 16'h0000, SIGN_BIT = 15.
- One sub-module, treino_amostras: N_MAX x 4*TAM sample RAM with synchronous write and asynchronous read at the current index.

Test Plan:
- Reset: rst high 2 cycles → busy = 0, done = 0, w_out = 0, all dp_*_en = 0.
- Single update, LAT = 2, u = 16'h3800, w = 0, one sample x = (3C00, 3C00, 3C00), d = 0000:
  - v = 0 gives y = 3C00, an error → each weight becomes B800.
  - Enable sequence: calc 2 cycles, ativ 2, att 2+2+2; 12 cycles per sample.
  - dp_att_y = BC00 during the UPD states.
- Already correct: w = (3C00, 3C00, BC00), sample x = (3C00, 0000, 3C00), d = 3C00:
  - No dp_att_en pulse; done after 1 epoch; converged = 1; weights unchanged.
- AND training: 4 samples with bias x2 = 3C00, u = 3800, w = 0:
  - Converges in fewer than 10 epochs with converged = 1.
  - Final weights classify all 4 samples (checked against a reference model).
- Non-separable XOR with MAX_EPOCH = 4: done after exactly 4 epochs, converged = 0.
- Reset mid-UPD1: busy and dp_att_en drop the next cycle; no done pulse; a subsequent start runs normally.
